vga_timing_receiver: RTL and testbench
======================================

Name: vga_timing_receiver

Overview:
- Sink-side counterpart of the VGA timing generator; sits at the input of any block that consumes a VGA-timed pixel stream (capture, overlay, checker).
- Samples hsync, vsync and video_active on the pixel clock and recovers pixel_x/pixel_y.
- Measures line and frame lengths, and runs a lock state machine that declares the incoming timing valid against the expected 640x480 mode.

Parameters:
- H_TOTAL, 800, expected clocks per line.
- H_ACTIVE, 640, expected clocks with video_active high per line.
- V_TOTAL, 525, expected lines per frame.
- V_ACTIVE, 480, expected lines containing active video.
- LOCK_FRAMES, 2, consecutive matching frames required to assert locked (range 1..15).

Ports:
- clk  input  1  pixel clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- hsync  input  1  horizontal sync, active-high pulse.
- vsync  input  1  vertical sync, active-high pulse.
- video_active  input  1  data-enable from the source.
- pixel_x  output  10  column of the current active pixel; 0 when pixel_valid=0.
- pixel_y  output  10  row of the current active pixel; 0 when pixel_valid=0.
- pixel_valid  output  1  registered copy of video_active.
- line_start  output  1  1-cycle pulse on each hsync rising edge.
- frame_start  output  1  1-cycle pulse on each vsync rising edge.
- locked  output  1  high in the LOCKED state.
- h_total_meas  output  11  length of the last completed line, in clocks.
- v_total_meas  output  11  length of the last completed frame, in lines.
- err_count  output  8  saturating count of mismatched frames seen while LOCKED.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All outputs 0; all counters 0; internal previous-sample registers 0; state = SEARCH.
- Input sampling:
  - hsync, vsync and video_active go through one register stage (prev-sample regs).
  - Edges are detected as current input vs. registered sample.
  - All outputs are registered: exactly 1 clk latency from an input change to its effect.
- Horizontal counter h_cnt (11 bit):
  - Increments every clk and saturates at 2047.
  - On an hsync rising edge: h_total_meas <= h_cnt+1, h_cnt <= 0, line_start = 1.
  - The first hsync edge after SEARCH only resets h_cnt and does not update h_total_meas.
- Pixel x:
  - x_cnt is cleared on a video_active rising edge and increments each clk while video_active=1.
  - pixel_x = x_cnt while video_active is high, else 0.
  - Example: the first active pixel of a line gives pixel_x=0; the last gives 639.
- Active-line width:
  - On a video_active falling edge, the width (x_cnt+1) is compared with H_ACTIVE.
- Vertical counters:
  - line_cnt increments on each hsync rising edge.
  - y_cnt increments on each video_active falling edge, saturating at 1023.
  - pixel_y = y_cnt while video_active is high, else 0.
- Frame boundary (vsync rising edge):
  - v_total_meas <= line_cnt; frame_start = 1.
  - The frame is evaluated (below); then line_cnt, y_cnt and the frame error flag are cleared.
  - If vsync and hsync rise on the same clk, the hsync action is applied first, then the vsync action. The line is therefore counted in the frame being closed.
- Frame error flag (sticky within a frame), set by any of:
  - h_total_meas update != H_TOTAL;
  - active width != H_ACTIVE;
  - h_cnt reaching 2047.
- Frame match: error flag clear AND line_cnt == V_TOTAL AND y_cnt == V_ACTIVE.
- Lock state machine:
  - SEARCH: wait for the first vsync rising edge -> VERIFY with match_cnt = 0. That partial frame is not evaluated.
  - VERIFY, on each evaluated frame:
    - match: match_cnt++; when match_cnt reaches LOCK_FRAMES -> LOCKED.
    - mismatch: match_cnt = 0 and stay in VERIFY.
  - LOCKED, on each evaluated frame:
    - match: stay in LOCKED.
    - mismatch: err_count++ (saturates at 255), match_cnt = 0 -> VERIFY.
  - Any state: h_cnt reaching 2047 (loss of hsync) -> SEARCH immediately; err_count is unchanged.
- locked is high exactly while in LOCKED. It rises on the clk after the qualifying frame_start.
- pixel_x, pixel_y and pixel_valid are produced in every state. Consumers gate them with locked.

Test Plan:
- Reset held low, inputs toggling:
  - all outputs stay 0;
  - releasing reset_n mid-line gives no spurious frame_start or locked.
- Three ideal 800x525 frames driven:
  - h_total_meas=800, v_total_meas=525;
  - pixel_x runs 0..639 and pixel_y 0..479 in step with pixel_valid;
  - locked rises 1 clk after the 3rd vsync rising edge (1st edge -> VERIFY, 2nd and 3rd edges -> two matches with LOCK_FRAMES=2).
- While locked, a single frame with one line of 801 clocks:
  - at the next vsync, locked falls and err_count=1;
  - two further good frames re-assert locked.
- While locked, hsync stops for 2048 clocks:
  - on reaching 2047, state = SEARCH and locked=0;
  - err_count is unchanged.
- Frame with V_ACTIVE=479 active lines (one video_active pulse missing) while in VERIFY:
  - match_cnt resets to 0;
  - locked is delayed by exactly one additional frame.
- hsync and vsync rising on the same clk at a frame boundary:
  - v_total_meas includes that line (525);
  - line_start and frame_start pulse together.

Source files
------------

// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver
//   Sink-side timing recovery for a VGA-timed pixel stream. Samples
//   hsync/vsync/video_active once, recovers pixel coordinates, measures line
//   and frame lengths, and runs a SEARCH/VERIFY/LOCKED state machine that
//   declares lock once LOCK_FRAMES consecutive frames match the expected mode.
//
// Ports
//   clk           in   pixel clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   hsync         in   horizontal sync, active-high pulse
//   vsync         in   vertical sync, active-high pulse
//   video_active  in   data enable from the source
//   pixel_x       out  [9:0]  column of the current active pixel, 0 when idle
//   pixel_y       out  [9:0]  row of the current active pixel, 0 when idle
//   pixel_valid   out  registered video_active
//   line_start    out  1-clk pulse per hsync rising edge
//   frame_start   out  1-clk pulse per vsync rising edge
//   locked        out  high while in LOCKED
//   h_total_meas  out  [10:0] clocks in the last completed line
//   v_total_meas  out  [10:0] lines in the last completed frame
//   err_count     out  [7:0]  saturating count of frames lost while LOCKED
module vga_timing_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        video_active,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic [7:0]  err_count
);

  localparam logic [10:0] C_HT   = 11'(H_TOTAL);
  localparam logic [11:0] C_HA   = 12'(H_ACTIVE);
  localparam logic [10:0] C_VT   = 11'(V_TOTAL);
  localparam logic [9:0]  C_VA   = 10'(V_ACTIVE);
  localparam logic [3:0]  C_LOCK = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

  state_t      r_state;
  logic        r_hs_d, r_vs_d, r_de_d;
  logic [10:0] r_h_cnt;
  logic [10:0] r_x_cnt;
  logic [10:0] r_line_cnt;
  logic [9:0]  r_y_cnt;
  logic        r_frame_err;
  logic        r_h_valid;
  logic [3:0]  r_match_cnt;
  logic [7:0]  r_err_count;
  logic [10:0] r_h_meas, r_v_meas;
  logic [9:0]  r_pix_y;
  logic        r_pix_valid, r_line_start, r_frame_start;

  logic        w_hs_rise, w_vs_rise, w_de_rise, w_de_fall;
  logic        w_h_sat, w_h_bad, w_w_bad, w_err_nxt, w_match;
  logic [10:0] w_h_meas, w_line_nxt;
  logic [11:0] w_width;
  logic [9:0]  w_y_nxt;

  assign w_hs_rise = hsync & ~r_hs_d;
  assign w_vs_rise = vsync & ~r_vs_d;
  assign w_de_rise = video_active & ~r_de_d;
  assign w_de_fall = ~video_active & r_de_d;

  // Fires on the clk where h_cnt steps onto 2047: hsync is considered lost.
  assign w_h_sat  = (r_h_cnt == 11'd2046) && !w_hs_rise;
  assign w_h_meas = (r_h_cnt == 11'd2047) ? 11'd2047 : r_h_cnt + 11'd1;
  assign w_h_bad  = w_hs_rise && r_h_valid && (w_h_meas != C_HT);
  assign w_width  = {1'b0, r_x_cnt} + 12'd1;
  assign w_w_bad  = w_de_fall && (w_width != C_HA);

  // Line/active-row counts after this clk's hsync and video_active edges,
  // so a line closing on the same clk as vsync belongs to the old frame.
  assign w_line_nxt = (w_hs_rise && r_line_cnt != 11'd2047) ? r_line_cnt + 11'd1 : r_line_cnt;
  assign w_y_nxt    = (w_de_fall && r_y_cnt != 10'd1023) ? r_y_cnt + 10'd1 : r_y_cnt;
  assign w_err_nxt  = r_frame_err | w_h_bad | w_w_bad | w_h_sat;
  assign w_match    = !w_err_nxt && (w_line_nxt == C_VT) && (w_y_nxt == C_VA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_d        <= 1'b0;
      r_vs_d        <= 1'b0;
      r_de_d        <= 1'b0;
      r_h_cnt       <= '0;
      r_x_cnt       <= '0;
      r_line_cnt    <= '0;
      r_y_cnt       <= '0;
      r_frame_err   <= 1'b0;
      r_h_meas      <= '0;
      r_v_meas      <= '0;
      r_pix_y       <= '0;
      r_pix_valid   <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hs_d        <= hsync;
      r_vs_d        <= vsync;
      r_de_d        <= video_active;
      r_line_start  <= w_hs_rise;
      r_frame_start <= w_vs_rise;
      r_pix_valid   <= video_active;

      if (w_hs_rise) begin
        r_h_cnt <= '0;
        if (r_h_valid) r_h_meas <= w_h_meas;
      end else if (r_h_cnt != 11'd2047) begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end

      // x_cnt doubles as pixel_x: cleared whenever the source is idle.
      if (!video_active || w_de_rise)  r_x_cnt <= '0;
      else if (r_x_cnt != 11'd2047)    r_x_cnt <= r_x_cnt + 11'd1;

      r_pix_y <= video_active ? (w_vs_rise ? 10'd0 : r_y_cnt) : 10'd0;

      if (w_vs_rise) begin
        r_v_meas    <= w_line_nxt;
        r_line_cnt  <= '0;
        r_y_cnt     <= '0;
        r_frame_err <= 1'b0;
      end else begin
        r_line_cnt  <= w_line_nxt;
        r_y_cnt     <= w_y_nxt;
        r_frame_err <= w_err_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_SEARCH;
      r_match_cnt <= '0;
      r_err_count <= '0;
      r_h_valid   <= 1'b0;
    end else begin
      // The first hsync edge after losing sync only realigns h_cnt.
      if (w_h_sat)        r_h_valid <= 1'b0;
      else if (w_hs_rise) r_h_valid <= 1'b1;

      if (w_h_sat) begin
        r_state     <= ST_SEARCH;
        r_match_cnt <= '0;
      end else if (w_vs_rise) begin
        case (r_state)
          ST_SEARCH: begin
            r_state     <= ST_VERIFY;
            r_match_cnt <= '0;
          end
          ST_VERIFY: begin
            if (w_match) begin
              r_match_cnt <= r_match_cnt + 4'd1;
              if (r_match_cnt + 4'd1 == C_LOCK) r_state <= ST_LOCKED;
            end else begin
              r_match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (!w_match) begin
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
              r_match_cnt <= '0;
              r_state     <= ST_VERIFY;
            end
          end
          default: r_state <= ST_SEARCH;
        endcase
      end
    end
  end

  assign pixel_x      = r_x_cnt[9:0];
  assign pixel_y      = r_pix_y;
  assign pixel_valid  = r_pix_valid;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;
  assign locked       = (r_state == ST_LOCKED);
  assign h_total_meas = r_h_meas;
  assign v_total_meas = r_v_meas;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// tb_vga_timing_receiver
//   Directed bench for vga_timing_receiver using a reduced timing mode
//   (64 clocks x 20 lines, 40 x 12 active) so whole frames stay short.
//   Expected values are hand-derived from the generator geometry below.
module tb_vga_timing_receiver;

  localparam int HT  = 64;   // clocks per line
  localparam int HA  = 40;   // active clocks per line
  localparam int HSW = 8;    // hsync pulse width
  localparam int HST = 16;   // first active clock in a line
  localparam int VT  = 20;   // lines per frame
  localparam int VA  = 12;   // active lines
  localparam int VST = 4;    // first active line
  localparam int VSW = 2;    // vsync width in lines
  // Truncated frame before hsync loss has 5 lines; the last hsync leaves
  // h_cnt at HT-1 when the line ends, so it steps onto 2047 after this many idle clks.
  localparam int JSAT = 2047 - (HT - 1);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        video_active = 1'b0;
  logic [9:0]  pixel_x, pixel_y;
  logic        pixel_valid, line_start, frame_start, locked;
  logic [10:0] h_total_meas, v_total_meas;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing_receiver #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .video_active(video_active), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .line_start(line_start), .frame_start(frame_start),
    .locked(locked), .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
    .err_count(err_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [53:0] all_out();
    return {pixel_x, pixel_y, pixel_valid, line_start, frame_start, locked,
            h_total_meas, v_total_meas, err_count};
  endfunction

  // Drives nlines lines of a frame; hsync and vsync rise together at line 0.
  task automatic run_frame(input int nlines, input int long_line, input int skip_line,
                           input logic exp_lock, input int exp_vtm, input int exp_err,
                           input bit chk_pix);
    for (int ln = 0; ln < nlines; ln++) begin
      int len;
      len = (ln == long_line) ? HT + 1 : HT;
      for (int h = 0; h < len; h++) begin
        hsync        = (h < HSW);
        vsync        = (ln < VSW);
        video_active = (ln >= VST) && (ln < VST + VA) && (ln != skip_line) &&
                       (h >= HST) && (h < HST + HA);
        tick();
        if (ln == 0 && h == 0) begin
          check("ls_fs_together", 64'({line_start, frame_start}), 64'(2'b11));
          check("locked_at_fs", 64'(locked), 64'(exp_lock));
          check("v_total_meas", 64'(v_total_meas), 64'(exp_vtm));
          check("err_count", 64'(err_count), 64'(exp_err));
        end
        if (ln == 0 && h == 1)
          check("pulse_width", 64'({line_start, frame_start}), 64'(2'b00));
        if (ln == 1 && h == 0) begin
          check("line_start_only", 64'({line_start, frame_start}), 64'(2'b10));
          check("h_total_meas", 64'(h_total_meas), 64'(HT));
        end
        if (long_line >= 0 && ln == long_line + 1 && h == 0)
          check("h_total_long", 64'(h_total_meas), 64'(HT + 1));
        if (chk_pix) begin
          if (ln == VST && h == HST)
            check("pix_first", 64'({pixel_valid, pixel_x, pixel_y}), 64'({1'b1, 10'd0, 10'd0}));
          if (ln == VST && h == HST + HA - 1)
            check("pix_x_last", 64'(pixel_x), 64'(HA - 1));
          if (ln == 8 && h == 30)
            check("pix_mid", 64'({pixel_valid, pixel_x, pixel_y}), 64'({1'b1, 10'd14, 10'd4}));
          if (ln == VST + VA - 1 && h == HST + HA - 1)
            check("pix_last", 64'({pixel_valid, pixel_x, pixel_y}), 64'({1'b1, 10'd39, 10'd11}));
          if (ln == VST + VA - 1 && h == HST + HA)
            check("pix_idle", 64'({pixel_valid, pixel_x, pixel_y}), 64'({1'b0, 10'd0, 10'd0}));
        end
      end
    end
  endtask

  initial begin
    logic any_fs, any_ls, any_lk;

    // Reset held with toggling inputs.
    for (int i = 0; i < 200; i++) begin
      hsync        = (i % 50) < 5;
      vsync        = (i % 120) < 3;
      video_active = (i % 7) < 3;
      tick();
      if (i % 50 == 49) check("reset_outputs", 64'(all_out()), 64'(0));
    end

    // Release mid-line (sync low, inside active video).
    hsync = 1'b0;
    vsync = 1'b0;
    video_active = 1'b1;
    #2 reset_n = 1'b1;
    any_fs = 1'b0;
    any_ls = 1'b0;
    any_lk = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      any_fs |= frame_start;
      any_ls |= line_start;
      any_lk |= locked;
    end
    check("no_spurious_fs", 64'(any_fs), 64'(0));
    check("no_spurious_ls", 64'(any_ls), 64'(0));
    check("no_spurious_lock", 64'(any_lk), 64'(0));
    check("valid_after_rst", 64'(pixel_valid), 64'(1));

    // Three ideal frames: lock on the third vsync edge.
    run_frame(VT, -1, -1, 1'b0, 1,  0, 1'b1);
    run_frame(VT, -1, -1, 1'b0, VT, 0, 1'b1);
    run_frame(VT, -1, -1, 1'b1, VT, 0, 1'b0);
    // Locked; this frame has one 65-clock line.
    run_frame(VT,  8, -1, 1'b1, VT, 0, 1'b0);
    // Lost lock, err_count=1, then two good frames re-lock.
    run_frame(VT, -1, -1, 1'b0, VT, 1, 1'b0);
    run_frame(VT, -1, -1, 1'b0, VT, 1, 1'b0);
    run_frame(5,  -1, -1, 1'b1, VT, 1, 1'b0);

    // hsync stops while locked.
    for (int j = 1; j <= 2100; j++) begin
      hsync = 1'b0;
      vsync = 1'b0;
      video_active = 1'b0;
      tick();
      if (j == JSAT - 1) check("locked_before_sat", 64'(locked), 64'(1));
      if (j == JSAT)     check("locked_at_sat", 64'(locked), 64'(0));
    end
    check("err_after_loss", 64'(err_count), 64'(1));
    check("htm_after_loss", 64'(h_total_meas), 64'(HT));

    // First VERIFY frame is missing one active line: lock one frame late.
    run_frame(VT, -1, 10, 1'b0, 5,  1, 1'b0);
    run_frame(VT, -1, -1, 1'b0, VT, 1, 1'b0);
    run_frame(VT, -1, -1, 1'b0, VT, 1, 1'b0);
    run_frame(3,  -1, -1, 1'b1, VT, 1, 1'b0);
    check("locked_final", 64'(locked), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
